// File: rtl/fallback_bridge_mc.sv
// fallback_bridge_mc: per-lane fallback event FIFOs drained round-robin into one registered host IRQ channel
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   fail_valid     per-lane event strobe (NUM_CH)
//   fail_func_id   per-lane function id, lane i at [i*16 +: 16]
//   fail_token     per-lane token, lane i at [i*64 +: 64]
//   host_ready     host accepts the presented irq word
//   irq_valid      irq word present (registered)
//   irq_data       {token_hash[47:0], func_id[15:0]}
//   irq_ch         source lane of irq_data
//   cnt_overflows  per-lane saturating overflow counters, lane i at [i*32 +: 32]
//   fifo_level     per-lane occupancy, lane i at [i*LW +: LW]
//   irq_ts         enqueue cycle stamp aligned with irq_data (only with HDU_FB_TIMESTAMP_EN)
// Optional feature macro: HDU_FB_TIMESTAMP_EN
module fallback_bridge_mc #(
  parameter int NUM_CH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FUNC_ID_WIDTH = 16,
  parameter int TOKEN_WIDTH = 64,
  parameter int DROP_OLDEST = 0,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               fail_valid,
  input  logic [NUM_CH*FUNC_ID_WIDTH-1:0] fail_func_id,
  input  logic [NUM_CH*TOKEN_WIDTH-1:0]   fail_token,
  input  logic                            host_ready,
  output logic                            irq_valid,
  output logic [63:0]                     irq_data,
  output logic [CW-1:0]                   irq_ch,
  output logic [NUM_CH*32-1:0]            cnt_overflows,
  output logic [NUM_CH*LW-1:0]            fifo_level
`ifdef HDU_FB_TIMESTAMP_EN
  ,
  output logic [31:0]                     irq_ts
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef HDU_FB_TIMESTAMP_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif
  logic [EW-1:0] mem [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr [NUM_CH];
  logic [PW-1:0] wr_ptr [NUM_CH];
  logic [LW-1:0] cnt [NUM_CH];
  logic [31:0] ovf_cnt [NUM_CH];
  logic [63:0] word [NUM_CH];
  logic [EW-1:0] wdata [NUM_CH];
  logic [EW-1:0] head;
  logic [NUM_CH-1:0] full, evict, elig, pop, push, ovf;
  logic [CW-1:0] last, gnt, idx;
  logic load, found;
`ifdef HDU_FB_TIMESTAMP_EN
  logic [31:0] ts;
`endif
  always_comb begin
    load = !irq_valid || host_ready;
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      word[i] = {fail_token[i*TOKEN_WIDTH+16 +: 48] ^ {32'b0, fail_token[i*TOKEN_WIDTH +: 16]},
                 fail_func_id[i*FUNC_ID_WIDTH +: 16]};
`ifdef HDU_FB_TIMESTAMP_EN
      wdata[i] = {ts, word[i]};
`else
      wdata[i] = word[i];
`endif
      full[i] = cnt[i] == LW'(FIFO_DEPTH);
      // an evicting lane rewrites its own head this cycle, so it sits out arbitration
      evict[i] = (DROP_OLDEST != 0) && fail_valid[i] && full[i];
      elig[i] = (cnt[i] != '0) && !evict[i];
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CW'((int'(last) + 1 + k) % NUM_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = load && found && (gnt == CW'(i));
      // a full lane that is popped in the same cycle accepts the push as a normal write
      push[i] = fail_valid[i] && (!full[i] || pop[i] || evict[i]);
      ovf[i] = fail_valid[i] && full[i] && !pop[i];
    end
    head = mem[gnt][rd_ptr[gnt]];
    fifo_level = '0;
    cnt_overflows = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_level[i*LW +: LW] = cnt[i];
      cnt_overflows[i*32 +: 32] = ovf_cnt[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_valid <= 1'b0;
      irq_data <= '0;
      irq_ch <= '0;
      last <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i] <= '0;
        ovf_cnt[i] <= '0;
      end
    end else begin
      if (load) begin
        irq_valid <= found;
        if (found) begin
          irq_data <= head[63:0];
          irq_ch <= gnt;
          last <= gnt;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= wdata[i];
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i] || evict[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + LW'(push[i]) - LW'(pop[i] || evict[i]);
        if (ovf[i] && ovf_cnt[i] != '1) ovf_cnt[i] <= ovf_cnt[i] + 32'd1;
      end
    end
  end
`ifdef HDU_FB_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      irq_ts <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (load && found) irq_ts <= head[95:64];
    end
  end
`endif
`ifndef SYNTHESIS
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lvl
    a_level: assert property (@(posedge clk) disable iff (rst) cnt[k] <= LW'(FIFO_DEPTH));
  end
  a_stall: assert property (@(posedge clk) disable iff (rst)
    irq_valid && !host_ready |=> irq_valid && $stable(irq_data) && $stable(irq_ch));
`endif
endmodule

// File: tb/tb_fallback_bridge_mc.sv
// tb_fallback_bridge_mc: checks fallback_bridge_mc (both full-queue policies) against a queue-based model
module tb_fallback_bridge_mc;
  localparam int NCH = 4;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hr = 1'b0;
  logic [NCH-1:0] fv = '0;
  logic [NCH*16-1:0] fid_bus = '0;
  logic [NCH*64-1:0] tok_bus = '0;
  logic [1:0] v;
  logic [1:0][63:0] d;
  logic [1:0][1:0] c;
  logic [1:0][NCH*32-1:0] ov;
  logic [1:0][NCH*4-1:0] lv;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  fallback_bridge_mc #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .DROP_OLDEST(0)) dut0 (
    .clk(clk), .rst(rst), .fail_valid(fv), .fail_func_id(fid_bus), .fail_token(tok_bus),
    .host_ready(hr), .irq_valid(v[0]), .irq_data(d[0]), .irq_ch(c[0]),
    .cnt_overflows(ov[0]), .fifo_level(lv[0]));
  fallback_bridge_mc #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .DROP_OLDEST(1)) dut1 (
    .clk(clk), .rst(rst), .fail_valid(fv), .fail_func_id(fid_bus), .fail_token(tok_bus),
    .host_ready(hr), .irq_valid(v[1]), .irq_data(d[1]), .irq_ch(c[1]),
    .cnt_overflows(ov[1]), .fifo_level(lv[1]));
  // reference model: one queue per lane, instance 0 discards on full, instance 1 evicts oldest
  logic [63:0] mq [2][NCH][$];
  bit mv [2];
  logic [63:0] md [2];
  int mc [2];
  int ml [2];
  int unsigned mo [2][NCH];
  function automatic logic [63:0] pack(input logic [15:0] f, input logic [63:0] t);
    return {t[63:16] ^ {32'b0, t[15:0]}, f};
  endfunction
  function automatic logic [63:0] wn(input int n);
    return {32'd0, 16'(n), 16'(n)};
  endfunction
  task automatic model_step(input int m);
    int g;
    int l;
    bit load;
    logic [63:0] w;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mq[m][i].delete();
        mo[m][i] = 0;
      end
      mv[m] = 0;
      md[m] = '0;
      mc[m] = 0;
      ml[m] = 0;
      return;
    end
    load = !mv[m] || hr;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      l = (ml[m] + 1 + k) % NCH;
      if (g < 0 && mq[m][l].size() > 0 && !(m == 1 && fv[l] && mq[m][l].size() == DEPTH)) g = l;
    end
    if (load) begin
      mv[m] = (g >= 0);
      if (g >= 0) begin
        md[m] = mq[m][g].pop_front();
        mc[m] = g;
        ml[m] = g;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (fv[i]) begin
        w = pack(fid_bus[i*16 +: 16], tok_bus[i*64 +: 64]);
        if (mq[m][i].size() < DEPTH) mq[m][i].push_back(w);
        else begin
          if (m == 1) begin
            void'(mq[m][i].pop_front());
            mq[m][i].push_back(w);
          end
          if (mo[m][i] != 32'hFFFF_FFFF) mo[m][i]++;
        end
      end
    end
  endtask
  always @(posedge clk) for (int m = 0; m < 2; m++) model_step(m);
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cmp_model();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model valid dut%0d", m), 64'(v[m]), 64'(mv[m]));
      if (mv[m]) begin
        chk($sformatf("model data dut%0d", m), d[m], md[m]);
        chk($sformatf("model ch dut%0d", m), 64'(c[m]), 64'(mc[m]));
      end
      for (int l = 0; l < NCH; l++) begin
        chk($sformatf("model level dut%0d lane%0d", m, l), 64'(lv[m][l*4 +: 4]), 64'(mq[m][l].size()));
        chk($sformatf("model ovf dut%0d lane%0d", m, l), 64'(ov[m][l*32 +: 32]), 64'(mo[m][l]));
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
  endtask
  task automatic set_ev(input int l, input logic [15:0] f, input logic [63:0] t);
    fv[l] = 1'b1;
    fid_bus[l*16 +: 16] = f;
    tok_bus[l*64 +: 64] = t;
  endtask
  typedef struct {
    int lane;
    logic [15:0] fid;
    logic [63:0] tok;
    logic [63:0] word;
  } vec_t;
  vec_t tv [6];
  logic [63:0] got [2][$];
  logic [63:0] dl [2][$];
  logic [63:0] bp_exp [$];
  int e0 [$];
  int e1 [$];
  logic [1:0] pv;
  logic [1:0][63:0] pd;
  logic [1:0][1:0] pc;
  logic phr;
  int hits;
  initial begin
    tv[0] = '{2, 16'h00AB, 64'h1111_2222_3333_4444, 64'h1111_2222_7777_00AB};
    tv[1] = '{0, 16'h1234, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_1234};
    tv[2] = '{1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_FFFF};
    tv[3] = '{0, 16'h0001, 64'h8000_0000_0001_0002, 64'h8000_0000_0003_0001};
    tv[4] = '{3, 16'hBEEF, 64'h0000_0000_0000_ABCD, 64'h0000_0000_ABCD_BEEF};
    tv[5] = '{3, 16'h5A5A, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_3AF3_5A5A};
    e0 = '{2, 3, 4, 5, 6, 7, 8, 9, 12};
    e1 = '{5, 6, 7, 8, 9, 10, 11, 12};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("reset valid", 64'(v[m]), 64'd0);
      chk("reset data", d[m], 64'd0);
      chk("reset ch", 64'(c[m]), 64'd0);
      chk("reset level", 64'(lv[m]), 64'd0);
      chk("reset ovf", 64'(ov[m] != '0), 64'd0);
    end
    hr = 1'b1;
    foreach (tv[i]) begin
      set_ev(tv[i].lane, tv[i].fid, tv[i].tok);
      tick();
      fv = '0;
      for (int m = 0; m < 2; m++) begin
        chk("vec level", 64'(lv[m][tv[i].lane*4 +: 4]), 64'd1);
        chk("vec early valid", 64'(v[m]), 64'd0);
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        chk("vec valid", 64'(v[m]), 64'd1);
        chk("vec data", d[m], tv[i].word);
        chk("vec ch", 64'(c[m]), 64'(tv[i].lane));
      end
      tick();
      tick();
    end
    hr = 1'b0;
    fv = '1;
    tok_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    tok_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    fv = '0;
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("fair valid %0d", i), 64'(v[m]), 64'd1);
        chk($sformatf("fair ch %0d", i), 64'(c[m]), 64'(i % 4));
      end
      hr = 1'b1;
      tick();
    end
    for (int m = 0; m < 2; m++) chk("fair drained", 64'(v[m]), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hr = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      fv = '0;
      set_ev(0, 16'(n), 64'(n));
      tick();
    end
    fv = '0;
    for (int m = 0; m < 2; m++) begin
      chk("ovf level", 64'(lv[m][3:0]), 64'd8);
      chk("ovf count", 64'(ov[m][31:0]), 64'd2);
      chk("ovf head reg", d[m], wn(1));
    end
    hr = 1'b1;
    set_ev(0, 16'd12, 64'd12);
    tick();
    fv = '0;
    chk("pop+push ovf dut0", 64'(ov[0][31:0]), 64'd2);
    chk("pop+push level dut0", 64'(lv[0][3:0]), 64'd8);
    chk("pop+push data dut0", d[0], wn(2));
    chk("evict ovf dut1", 64'(ov[1][31:0]), 64'd3);
    chk("evict level dut1", 64'(lv[1][3:0]), 64'd8);
    chk("evict skip valid dut1", 64'(v[1]), 64'd0);
    for (int i = 0; i < 14; i++) begin
      for (int m = 0; m < 2; m++) if (v[m]) got[m].push_back(d[m]);
      tick();
    end
    chk("drain count dut0", 64'(got[0].size()), 64'(e0.size()));
    chk("drain count dut1", 64'(got[1].size()), 64'(e1.size()));
    for (int i = 0; i < e0.size() && i < got[0].size(); i++) chk("drain order dut0", got[0][i], wn(e0[i]));
    for (int i = 0; i < e1.size() && i < got[1].size(); i++) chk("drain order dut1", got[1][i], wn(e1[i]));
    hr = 1'b0;
    fv = 4'b0111;
    tick();
    tick();
    fv = '0;
    for (int m = 0; m < 2; m++) begin
      chk("pre-reset valid", 64'(v[m]), 64'd1);
      chk("pre-reset levels", 64'(lv[m]), 64'h0212);
    end
    rst = 1'b1;
    fv = '1;
    tick();
    rst = 1'b0;
    fv = '0;
    for (int m = 0; m < 2; m++) begin
      chk("mid-reset valid", 64'(v[m]), 64'd0);
      chk("mid-reset data", d[m], 64'd0);
      chk("mid-reset ch", 64'(c[m]), 64'd0);
      chk("mid-reset levels", 64'(lv[m]), 64'd0);
      chk("mid-reset ovf", 64'(ov[m][31:0]), 64'd0);
    end
    hr = 1'b1;
    set_ev(2, 16'h00AB, 64'h1111_2222_3333_4444);
    tick();
    fv = '0;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("post-reset valid", 64'(v[m]), 64'd1);
      chk("post-reset data", d[m], 64'h1111_2222_7777_00AB);
      chk("post-reset ch", 64'(c[m]), 64'd2);
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      bp_exp.push_back(pack(16'(k), 64'(32'h100 + k)));
      bp_exp.push_back(pack(16'(k + 8), 64'(32'h300 + k)));
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      fv = '0;
      if (cyc < 4) begin
        set_ev(1, 16'(cyc), 64'(32'h100 + cyc));
        set_ev(3, 16'(cyc + 8), 64'(32'h300 + cyc));
      end
      hr = (cyc % 2 == 0);
      pv = v;
      pd = d;
      pc = c;
      phr = hr;
      tick();
      for (int m = 0; m < 2; m++) begin
        if (pv[m] && !phr) begin
          chk("stall valid", 64'(v[m]), 64'd1);
          chk("stall data", d[m], pd[m]);
          chk("stall ch", 64'(c[m]), 64'(pc[m]));
        end
        if (pv[m] && phr) dl[m].push_back(pd[m]);
      end
    end
    fv = '0;
    for (int m = 0; m < 2; m++) begin
      chk("bp delivered count", 64'(dl[m].size()), 64'd8);
      foreach (bp_exp[j]) begin
        hits = 0;
        foreach (dl[m][k]) if (dl[m][k] == bp_exp[j]) hits++;
        chk("bp delivered once", 64'(hits), 64'd1);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 499) == 0);
      fv = 4'($urandom);
      if ((cyc / 250) % 2 == 0) fv = fv & 4'($urandom);
      hr = ((cyc / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fid_bus = {$urandom, $urandom};
      tok_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    fv = '0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
